// File: rtl/id_stage_if.sv
// Fetch/writeback/hazard inputs and ID/EX pipeline outputs of the decode stage.
// The master drives the stage inputs; the slave is the decode stage.
interface id_stage_if;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en;
  logic [4:0]  exe_dest;
  logic        mem_wb_en;
  logic [4:0]  mem_dest;
  logic        freeze;
  logic [31:0] pc_out;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] st_val;
  logic [4:0]  dest;
  logic [3:0]  exe_cmd;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en_out;
  logic [1:0]  br_type;

  modport master (
    output pc_in, instruction, flush, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    input  freeze, pc_out, val1, val2, st_val, dest, exe_cmd,
           mem_r_en, mem_w_en, wb_en_out, br_type
  );

  modport slave (
    input  pc_in, instruction, flush, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    output freeze, pc_out, val1, val2, st_val, dest, exe_cmd,
           mem_r_en, mem_w_en, wb_en_out, br_type
  );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: field decode, register file with WB bypass, RAW hazard
// detection against EX/MEM, and the ID/EX pipeline register.
module id_stage #(
  parameter int REG_COUNT = 32
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [31:0] rf_q [REG_COUNT];

  logic [5:0]         opcode;
  logic [4:0]         src1, src2, rd;
  logic signed [31:0] imm_sext;
  logic [31:0]        rs1_val, rs2_val;

  logic [3:0] cmd_dec;
  logic [4:0] dest_dec;
  logic       mr_dec, mw_dec, wb_dec, imm_sel, use1, use2;
  logic [1:0] br_dec;
  logic       freeze;

  logic [31:0] pc_d, val1_d, val2_d, st_val_d;
  logic [4:0]  dest_d;
  logic [3:0]  cmd_d;
  logic        mr_d, mw_d, wb_d;
  logic [1:0]  br_d;

  logic [31:0] pc_q, val1_q, val2_q, st_val_q;
  logic [4:0]  dest_q;
  logic [3:0]  cmd_q;
  logic        mr_q, mw_q, wb_q;
  logic [1:0]  br_q;

  // The writeback port is bypassed so WB never needs to stall decode.
  function automatic logic [31:0] rf_read(input logic [4:0] s);
    if (s == 5'd0)
      return 32'd0;
    else if (bus.wb_en && bus.wb_dest == s)
      return bus.wb_value;
    else
      return rf_q[s];
  endfunction

  function automatic logic raw_hit(input logic [4:0] s);
    return (s != 5'd0) &&
           ((bus.exe_wb_en && s == bus.exe_dest) ||
            (bus.mem_wb_en && s == bus.mem_dest));
  endfunction

  assign opcode   = bus.instruction[31:26];
  assign src1     = bus.instruction[25:21];
  assign src2     = bus.instruction[20:16];
  assign rd       = bus.instruction[15:11];
  assign imm_sext = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
  assign rs1_val  = rf_read(src1);
  assign rs2_val  = rf_read(src2);

  always_comb begin
    cmd_dec  = 4'd0;
    dest_dec = 5'd0;
    mr_dec   = 1'b0;
    mw_dec   = 1'b0;
    wb_dec   = 1'b0;
    br_dec   = 2'b00;
    imm_sel  = 1'b1;
    use1     = 1'b0;
    use2     = 1'b0;
    case (opcode)
      6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100: begin
        dest_dec = rd;
        wb_dec   = 1'b1;
        imm_sel  = 1'b0;
        use1     = 1'b1;
        use2     = 1'b1;
        case (opcode)
          6'b000011: cmd_dec = 4'b0010;
          6'b000101: cmd_dec = 4'b0100;
          6'b000110: cmd_dec = 4'b0101;
          6'b000111: cmd_dec = 4'b0110;
          6'b001000: cmd_dec = 4'b0111;
          6'b001001: cmd_dec = 4'b1000;
          6'b001010: cmd_dec = 4'b1001;
          6'b001011: cmd_dec = 4'b1010;
          6'b001100: cmd_dec = 4'b1011;
          default:   cmd_dec = 4'b0000;
        endcase
      end
      6'b100000, 6'b100001, 6'b100100: begin
        dest_dec = src2;
        wb_dec   = 1'b1;
        use1     = 1'b1;
        cmd_dec  = (opcode == 6'b100001) ? 4'b0010 : 4'b0000;
        mr_dec   = (opcode == 6'b100100);
      end
      6'b100101: begin
        mw_dec = 1'b1;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      6'b101000: begin
        br_dec = 2'b01;
        use1   = 1'b1;
      end
      6'b101001: begin
        br_dec = 2'b10;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      6'b101010: br_dec = 2'b11;
      default: ;
    endcase
  end

  assign freeze = (use1 && raw_hit(src1)) || (use2 && raw_hit(src2));

  // flush and freeze both collapse into the same single bubble.
  always_comb begin
    pc_d     = bus.pc_in;
    val1_d   = rs1_val;
    val2_d   = imm_sel ? imm_sext : rs2_val;
    st_val_d = rs2_val;
    dest_d   = dest_dec;
    cmd_d    = cmd_dec;
    mr_d     = mr_dec;
    mw_d     = mw_dec;
    wb_d     = wb_dec && (dest_dec != 5'd0);
    br_d     = br_dec;
    if (bus.flush || freeze) begin
      pc_d     = 32'd0;
      val1_d   = 32'd0;
      val2_d   = 32'd0;
      st_val_d = 32'd0;
      dest_d   = 5'd0;
      cmd_d    = 4'd0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      wb_d     = 1'b0;
      br_d     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= 32'd0;
      pc_q     <= 32'd0;
      val1_q   <= 32'd0;
      val2_q   <= 32'd0;
      st_val_q <= 32'd0;
      dest_q   <= 5'd0;
      cmd_q    <= 4'd0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      wb_q     <= 1'b0;
      br_q     <= 2'b00;
    end else begin
      if (bus.wb_en && bus.wb_dest != 5'd0) rf_q[bus.wb_dest] <= bus.wb_value;
      pc_q     <= pc_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
      st_val_q <= st_val_d;
      dest_q   <= dest_d;
      cmd_q    <= cmd_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      wb_q     <= wb_d;
      br_q     <= br_d;
    end
  end

  assign bus.freeze    = freeze;
  assign bus.pc_out    = pc_q;
  assign bus.val1      = val1_q;
  assign bus.val2      = val2_q;
  assign bus.st_val    = st_val_q;
  assign bus.dest      = dest_q;
  assign bus.exe_cmd   = cmd_q;
  assign bus.mem_r_en  = mr_q;
  assign bus.mem_w_en  = mw_q;
  assign bus.wb_en_out = wb_q;
  assign bus.br_type   = br_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode table plus hazard/bypass/flush/reset sequences.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  id_stage_if bus ();

  id_stage #(.REG_COUNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        chk_data;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [1:0]  br;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [4:0] d);
    return {op, s1, s2, d, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [15:0] imm);
    return {op, s1, s2, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, " ctrl"}, {27'd0, bus.br_type, bus.wb_en_out, bus.mem_r_en, bus.mem_w_en}, 32'd0);
    chk({name, " dest"}, {23'd0, bus.dest, bus.exe_cmd}, 32'd0);
    chk({name, " data"}, bus.val1 | bus.val2 | bus.st_val | bus.pc_out, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_in = 32'd0; bus.instruction = 32'd0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_dest = 5'd0; bus.wb_value = 32'd0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = 5'd0;
    bus.mem_wb_en = 1'b0; bus.mem_dest = 5'd0;

    // Reset
    rst = 1'b0;
    tick(); tick();
    chk_bubble("reset");
    chk("reset freeze", {31'd0, bus.freeze}, 32'd0);
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.instruction = r_ins(6'b000001, 5'(i), 5'(i), 5'd0);
      tick();
      chk($sformatf("reset read r%0d", i), bus.val1 | bus.val2, 32'd0);
    end

    // Preload r1..r7 = 0x1000+i through the writeback port
    bus.instruction = 32'd0;
    for (int i = 1; i < 8; i++) begin
      bus.wb_en = 1'b1; bus.wb_dest = 5'(i); bus.wb_value = 32'h1000 + 32'(i);
      tick();
    end
    bus.wb_en = 1'b0; bus.wb_dest = 5'd0; bus.wb_value = 32'd0;

    //                instr                                pc  chk  val1       val2          st_val     dest cmd  mr mw wb br
    vecs.push_back('{r_ins(6'b000001,1,2,3),             32'h10,1, 32'h1001, 32'h1002,     32'h1002, 5'd3, 4'h0, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b000011,5,6,4),             32'h14,1, 32'h1005, 32'h1006,     32'h1006, 5'd4, 4'h2, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b000101,1,3,8),             32'h18,1, 32'h1001, 32'h1003,     32'h1003, 5'd8, 4'h4, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b000110,2,4,9),             32'h1C,1, 32'h1002, 32'h1004,     32'h1004, 5'd9, 4'h5, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b000111,3,5,10),            32'h20,1, 32'h1003, 32'h1005,     32'h1005, 5'd10,4'h6, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b001001,4,6,11),            32'h24,1, 32'h1004, 32'h1006,     32'h1006, 5'd11,4'h8, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b001010,5,7,12),            32'h28,1, 32'h1005, 32'h1007,     32'h1007, 5'd12,4'h9, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b001011,6,1,13),            32'h2C,1, 32'h1006, 32'h1001,     32'h1001, 5'd13,4'hA, 0,0,1,2'b00});
    vecs.push_back('{r_ins(6'b001100,7,2,31),            32'h30,1, 32'h1007, 32'h1002,     32'h1002, 5'd31,4'hB, 0,0,1,2'b00});
    vecs.push_back('{i_ins(6'b100000,1,7,16'hFFFF),      32'h34,1, 32'h1001, 32'hFFFFFFFF, 32'h1007, 5'd7, 4'h0, 0,0,1,2'b00});
    vecs.push_back('{i_ins(6'b100001,2,3,16'h7FFF),      32'h38,1, 32'h1002, 32'h00007FFF, 32'h1003, 5'd3, 4'h2, 0,0,1,2'b00});
    vecs.push_back('{i_ins(6'b100100,3,4,16'h8000),      32'h3C,1, 32'h1003, 32'hFFFF8000, 32'h1004, 5'd4, 4'h0, 1,0,1,2'b00});
    vecs.push_back('{i_ins(6'b100101,1,2,16'h0004),      32'h40,1, 32'h1001, 32'h00000004, 32'h1002, 5'd0, 4'h0, 0,1,0,2'b00});
    vecs.push_back('{i_ins(6'b101000,5,0,16'hFFFE),      32'h44,1, 32'h1005, 32'hFFFFFFFE, 32'h0,    5'd0, 4'h0, 0,0,0,2'b01});
    vecs.push_back('{i_ins(6'b101001,6,7,16'h0003),      32'h48,1, 32'h1006, 32'h00000003, 32'h1007, 5'd0, 4'h0, 0,0,0,2'b10});
    vecs.push_back('{i_ins(6'b101010,0,0,16'h0010),      32'h4C,1, 32'h0,    32'h00000010, 32'h0,    5'd0, 4'h0, 0,0,0,2'b11});
    vecs.push_back('{32'h20A10000,                       32'h50,1, 32'h1005, 32'h1001,     32'h1001, 5'd0, 4'h7, 0,0,0,2'b00});
    vecs.push_back('{i_ins(6'b100000,1,0,16'h0005),      32'h54,1, 32'h1001, 32'h00000005, 32'h0,    5'd0, 4'h0, 0,0,0,2'b00});
    vecs.push_back('{32'h00000000,                       32'h58,0, 32'h0,    32'h0,        32'h0,    5'd0, 4'h0, 0,0,0,2'b00});
    vecs.push_back('{i_ins(6'b111111,1,2,16'h1800),      32'h5C,0, 32'h0,    32'h0,        32'h0,    5'd0, 4'h0, 0,0,0,2'b00});

    foreach (vecs[i]) begin
      bus.instruction = vecs[i].instr;
      bus.pc_in       = vecs[i].pc;
      tick();
      chk($sformatf("v%0d ctrl", i),
          {22'd0, bus.exe_cmd, bus.br_type, bus.mem_r_en, bus.mem_w_en, bus.wb_en_out, bus.freeze},
          {22'd0, vecs[i].cmd, vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].wb, 1'b0});
      chk($sformatf("v%0d pc", i), bus.pc_out, vecs[i].pc);
      if (vecs[i].wb || !vecs[i].chk_data)
        chk($sformatf("v%0d dest", i), {27'd0, bus.dest}, {27'd0, vecs[i].dest});
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d val1", i), bus.val1, vecs[i].val1);
        chk($sformatf("v%0d val2", i), bus.val2, vecs[i].val2);
        chk($sformatf("v%0d st_val", i), bus.st_val, vecs[i].st_val);
      end
    end

    // ADDI r1,r0,1546
    bus.instruction = 32'h8001060A; bus.pc_in = 32'd4;
    tick();
    chk("addi dest", {27'd0, bus.dest}, 32'd1);
    chk("addi val2", bus.val2, 32'd1546);
    chk("addi ctrl", {27'd0, bus.exe_cmd, bus.wb_en_out}, {27'd0, 4'd0, 1'b1});
    chk("addi pc", bus.pc_out, 32'd4);

    // Writeback bypass into ADD r2,r0,r1
    bus.wb_en = 1'b1; bus.wb_dest = 5'd1; bus.wb_value = 32'h60A;
    bus.instruction = 32'h04011000; bus.pc_in = 32'd8;
    #1 chk("bypass freeze", {31'd0, bus.freeze}, 32'd0);
    tick();
    chk("bypass val2", bus.val2, 32'h60A);
    chk("bypass dest", {27'd0, bus.dest}, 32'd2);
    bus.wb_en = 1'b0; bus.wb_dest = 5'd0; bus.wb_value = 32'd0;

    // EX hazard on BEZ r5,1
    bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5;
    bus.instruction = 32'hA0A00001; bus.pc_in = 32'd12;
    #1 chk("ex haz freeze", {31'd0, bus.freeze}, 32'd1);
    tick();
    chk_bubble("ex haz bubble");
    chk("ex haz hold", {31'd0, bus.freeze}, 32'd1);
    bus.exe_wb_en = 1'b0;
    #1 chk("ex haz release", {31'd0, bus.freeze}, 32'd0);
    tick();
    chk("bez br", {30'd0, bus.br_type}, 32'd1);
    chk("bez val2", bus.val2, 32'd1);
    bus.exe_dest = 5'd0;

    // MEM hazard on ST src2, then r0 exemption
    bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd2;
    bus.instruction = 32'h94220000;
    #1 chk("st mem haz", {31'd0, bus.freeze}, 32'd1);
    bus.mem_dest = 5'd0;
    #1 chk("st r0 exempt", {31'd0, bus.freeze}, 32'd0);
    tick();
    chk("st ctrl", {30'd0, bus.mem_w_en, bus.wb_en_out}, {30'd0, 1'b1, 1'b0});
    chk("st st_val", bus.st_val, 32'h1002);
    // ADDI does not read src2, so a MEM match on that field must not stall
    bus.mem_dest = 5'd2;
    bus.instruction = i_ins(6'b100000, 5'd1, 5'd2, 16'd0);
    #1 chk("addi src2 unused", {31'd0, bus.freeze}, 32'd0);
    bus.mem_wb_en = 1'b0; bus.mem_dest = 5'd0;

    // Flush turns a valid SUB into a bubble
    bus.flush = 1'b1;
    bus.instruction = r_ins(6'b000011, 5'd1, 5'd2, 5'd3);
    tick();
    chk_bubble("flush");
    bus.flush = 1'b0;

    // Writeback lands while decode is frozen
    bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5;
    bus.instruction = 32'hA0A00001;
    bus.wb_en = 1'b1; bus.wb_dest = 5'd9; bus.wb_value = 32'hABCD;
    tick();
    chk("wb in freeze bubble", {30'd0, bus.br_type}, 32'd0);
    bus.wb_en = 1'b0; bus.wb_dest = 5'd0; bus.wb_value = 32'd0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = 5'd0;
    bus.instruction = i_ins(6'b101000, 5'd9, 5'd0, 16'd0);
    tick();
    chk("wb in freeze r9", bus.val1, 32'hABCD);
    chk("wb in freeze br", {30'd0, bus.br_type}, 32'd1);

    // flush and freeze together give one bubble, then the branch issues
    bus.flush = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5;
    bus.instruction = 32'hA0A00001; bus.pc_in = 32'd20;
    tick();
    chk_bubble("flush+freeze");
    bus.flush = 1'b0; bus.exe_wb_en = 1'b0; bus.exe_dest = 5'd0;
    tick();
    chk("after ff br", {30'd0, bus.br_type}, 32'd1);
    chk("after ff pc", bus.pc_out, 32'd20);

    // Reset mid-stall clears everything, freeze follows the live inputs
    bus.instruction = i_ins(6'b100101, 5'd1, 5'd2, 16'd0);
    tick();
    bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd1;
    rst = 1'b0;
    tick();
    chk_bubble("reset mid stall");
    chk("reset mid stall freeze", {31'd0, bus.freeze}, 32'd1);
    rst = 1'b1;
    bus.exe_wb_en = 1'b0; bus.exe_dest = 5'd0;
    bus.instruction = r_ins(6'b000001, 5'd1, 5'd9, 5'd3);
    tick();
    chk("post reset r1", bus.val1, 32'd0);
    chk("post reset r9", bus.val2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
